// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC, imem addressing, one-entry output register, redirects
//
// Purpose: owns the program counter, drives the asynchronous-read instruction memory
// address from it and presents each fetched word to decode through a one-entry
// valid/ready output register. Branch redirects from execute reload the PC and
// flush any held instruction.
//
// Ports:
//   clk             - single clock, all state updates on the rising edge
//   rst             - synchronous, active-high reset
//   start           - one-cycle pulse, IDLE/HALT -> RUN
//   imem_addr       - instruction memory address (always equals the PC register)
//   imem_data       - instruction memory read data for imem_addr, same cycle
//   redirect_valid  - branch/jump taken this cycle
//   redirect_target - new PC when redirect_valid=1
//   out_valid       - out_ins/out_pc hold a valid instruction
//   out_ready       - decode accepts the held instruction this cycle
//   out_ins         - fetched instruction
//   out_pc          - address out_ins was fetched from
//   halted          - FSM is in HALT
//   running         - FSM is in RUN
//
// Optional feature macro: FETCH_HALT_DETECT_EN - an all-ones instruction is delivered
// to decode and then stops fetch (RUN -> HALT) without advancing the PC.

module fetch_sequencer #(
  parameter int PC_WIDTH  = 8,
  parameter int INS_WIDTH = 32,
  parameter int START_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [INS_WIDTH-1:0] imem_data,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INS_WIDTH-1:0] out_ins,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic                 halted,
  output logic                 running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchState_t;

  fetchState_t         state;
  fetchState_t         stateNext;
  logic [PC_WIDTH-1:0] pc;
  logic                fetchFire;
  logic                haltHit;

  assign imem_addr = pc;
  assign running   = (state == RUN);
  assign halted    = (state == HALT);

  // A redirect always wins over a fetch; otherwise fetch whenever the output
  // register is empty or being emptied by decode this cycle.
  assign fetchFire = running && !redirect_valid && (!out_valid || out_ready);

`ifdef FETCH_HALT_DETECT_EN
  assign haltHit = fetchFire && (imem_data == {INS_WIDTH{1'b1}});
`else
  assign haltHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)   stateNext = RUN;
      RUN:     if (haltHit) stateNext = HALT;
      HALT:    if (start)   stateNext = RUN;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_WIDTH'(START_PC);
      out_valid <= 1'b0;
      out_ins   <= '0;
      out_pc    <= '0;
    end else if (redirect_valid) begin
      // Flush even an unaccepted instruction; out_ins/out_pc keep stale values.
      pc        <= redirect_target;
      out_valid <= 1'b0;
    end else if (fetchFire) begin
      out_valid <= 1'b1;
      out_ins   <= imem_data;
      out_pc    <= pc;
      // A halting word leaves the PC on itself so a later start re-fetches it.
      if (!haltHit) begin
        pc <= pc + PC_WIDTH'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer (vector table, corner sequences, random vs model)

module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [7:0]  out_pc;
  logic        halted;
  logic        running;

  logic [31:0] mem [256];
  assign imem_data = mem[imem_addr];

  fetch_sequencer #(.PC_WIDTH(8), .INS_WIDTH(32), .START_PC(0)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ins(out_ins),
    .out_pc(out_pc),
    .halted(halted),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the sequencer seen as "next address to fetch", a mode, and
  // a single holding slot for the instruction offered to decode.
  int          mMode;    // 0 idle, 1 run, 2 halt
  int          mPc;
  logic        mValid;
  logic [31:0] mIns;
  int          mOutPc;
  bit          haltFeature;

  task automatic modelStep(input bit r, input bit s, input bit rd, input int tgt, input bit rdy);
    bit          take;
    bit          stop;
    int          newMode;
    logic [31:0] word;
    if (r) begin
      mMode = 0; mPc = 0; mValid = 0; mIns = 0; mOutPc = 0;
      return;
    end
    word    = mem[mPc];
    take    = (mMode == 1) && !rd && (!mValid || rdy);
    stop    = haltFeature && take && (word == 32'hFFFF_FFFF);
    newMode = mMode;
    if (mMode != 1 && s) newMode = 1;
    if (stop) newMode = 2;
    if (rd) begin
      mPc = tgt; mValid = 0;
    end else if (take) begin
      mIns = word; mOutPc = mPc; mValid = 1;
      if (!stop) mPc = (mPc + 1) % 256;
    end else if (rdy) begin
      mValid = 0;
    end
    mMode = newMode;
  endtask

  // One clock: drive after the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input bit r, input bit s, input bit rd, input int tgt, input bit rdy);
    @(negedge clk);
    rst = r; start = s; redirect_valid = rd; redirect_target = 8'(tgt); out_ready = rdy;
    modelStep(r, s, rd, tgt, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic chkModel(input string tag);
    chk({tag, ".valid"},   32'(out_valid), 32'(mValid));
    chk({tag, ".out_pc"},  32'(out_pc),    32'(mOutPc));
    chk({tag, ".out_ins"}, out_ins,        mIns);
    chk({tag, ".addr"},    32'(imem_addr), 32'(mPc));
    chk({tag, ".running"}, 32'(running),   32'(mMode == 1));
    chk({tag, ".halted"},  32'(halted),    32'(mMode == 2));
  endtask

  typedef struct {
    bit r; bit s; bit rd; int tgt; bit rdy;
    bit eValid; int eOutPc; bit eRun; int eAddr;
  } vec_t;

  vec_t vt [18];

  initial begin
`ifdef FETCH_HALT_DETECT_EN
    haltFeature = 1'b1;
`else
    haltFeature = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00; out_ready = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = k;

    //        r  s  rd tgt    rdy  valid outpc run addr
    vt[0]  = '{1, 0, 0, 0,    1,   0,    0,    0,  0};
    vt[1]  = '{0, 1, 0, 0,    1,   0,    0,    1,  0};
    vt[2]  = '{0, 0, 0, 0,    1,   1,    0,    1,  1};
    vt[3]  = '{0, 0, 0, 0,    1,   1,    1,    1,  2};
    vt[4]  = '{0, 0, 0, 0,    1,   1,    2,    1,  3};
    vt[5]  = '{0, 0, 0, 0,    1,   1,    3,    1,  4};
    vt[6]  = '{0, 0, 0, 0,    1,   1,    4,    1,  5};
    vt[7]  = '{0, 0, 0, 0,    1,   1,    5,    1,  6};
    vt[8]  = '{0, 0, 0, 0,    0,   1,    5,    1,  6};
    vt[9]  = '{0, 0, 0, 0,    0,   1,    5,    1,  6};
    vt[10] = '{0, 0, 0, 0,    0,   1,    5,    1,  6};
    vt[11] = '{0, 0, 0, 0,    1,   1,    6,    1,  7};
    vt[12] = '{0, 0, 0, 0,    0,   1,    6,    1,  7};
    vt[13] = '{0, 0, 1, 8'h40, 0,  0,    6,    1,  8'h40};
    vt[14] = '{0, 0, 0, 0,    0,   1, 8'h40,   1,  8'h41};
    vt[15] = '{1, 0, 0, 0,    1,   0,    0,    0,  0};
    vt[16] = '{0, 1, 1, 8'h10, 1,  0,    0,    1,  8'h10};
    vt[17] = '{0, 0, 0, 0,    1,   1, 8'h10,   1,  8'h11};

    for (int i = 0; i < 18; i++) begin
      cycle(vt[i].r, vt[i].s, vt[i].rd, vt[i].tgt, vt[i].rdy);
      chk($sformatf("vec%0d.valid", i),   32'(out_valid), 32'(vt[i].eValid));
      chk($sformatf("vec%0d.out_pc", i),  32'(out_pc),    32'(vt[i].eOutPc));
      chk($sformatf("vec%0d.out_ins", i), out_ins,        32'(vt[i].eOutPc));
      chk($sformatf("vec%0d.running", i), 32'(running),   32'(vt[i].eRun));
      chk($sformatf("vec%0d.halted", i),  32'(halted),    32'd0);
      chk($sformatf("vec%0d.addr", i),    32'(imem_addr), 32'(vt[i].eAddr));
    end

    // PC wrap: stream from 250 across 255 -> 0 with no gap.
    cycle(0, 0, 1, 250, 1);
    for (int i = 0; i < 9; i++) begin
      cycle(0, 0, 0, 0, 1);
      chk("wrap.valid",   32'(out_valid), 32'd1);
      chk("wrap.out_pc",  32'(out_pc),    32'((250 + i) % 256));
      chk("wrap.out_ins", out_ins,        32'((250 + i) % 256));
    end

    // Halt word at address 3.
    mem[3] = 32'hFFFF_FFFF;
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("halt.valid",   32'(out_valid), 32'd1);
    chk("halt.out_pc",  32'(out_pc),    32'd3);
    chk("halt.out_ins", out_ins,        32'hFFFF_FFFF);
    chk("halt.halted",  32'(halted),    32'(haltFeature));
    chk("halt.addr",    32'(imem_addr), haltFeature ? 32'd3 : 32'd4);
    cycle(0, 0, 0, 0, 1);
    chk("halt.next_valid",  32'(out_valid), haltFeature ? 32'd0 : 32'd1);
    chk("halt.next_pc",     32'(out_pc),    haltFeature ? 32'd3 : 32'd4);
    chk("halt.next_addr",   32'(imem_addr), haltFeature ? 32'd3 : 32'd5);
    chk("halt.next_halted", 32'(halted),    32'(haltFeature));
    chk("halt.running",     32'(running),   32'(!haltFeature));
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("halt.refetch_pc", 32'(out_pc), haltFeature ? 32'd3 : 32'd6);
    mem[3] = 32'd3;

    // Randomized stimulus against the reference model.
    for (int k = 0; k < 256; k++)
      mem[k] = ($urandom_range(0, 99) < 4) ? 32'hFFFF_FFFF : $urandom;
    cycle(1, 0, 0, 0, 0);
    chkModel("rnd.reset");
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 8,
            int'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 70);
      chkModel("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the core: owns the program counter and drives the address of the asynchronous-read instruction memory (256 x 32-bit).
- Presents fetched instructions to decode through a one-entry output register with a valid/ready handshake.
- Accepts branch redirects from execute, flushing any held instruction.
- Sits between the instruction memory and the decode stage, replacing the free-running PC-plus-one adder.

Parameters:
- PC_WIDTH, 8, program counter / instruction memory address width (depth 2**PC_WIDTH).
- INS_WIDTH, 32, instruction width.
- START_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; moves the FSM from IDLE or HALT to RUN.
- imem_addr  output  PC_WIDTH  instruction memory address, driven combinationally from the PC register.
- imem_data  input  INS_WIDTH  instruction memory read data; valid in the same cycle as imem_addr.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  PC_WIDTH  new PC when redirect_valid=1.
- out_valid  output  1  out_ins/out_pc hold a valid instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_ins  output  INS_WIDTH  fetched instruction.
- out_pc  output  PC_WIDTH  address out_ins was fetched from.
- halted  output  1  FSM is in HALT.
- running  output  1  FSM is in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, taken at the first edge with rst=1, from any state and mid-operation:
  - pc=START_PC, state=IDLE.
  - out_valid=0, out_ins=0, out_pc=0.
  - halted=0, running=0.
  - rst overrides all other inputs.
- imem_addr = pc at all times, including during reset.
- FSM states: IDLE, RUN, HALT.
  - IDLE: start -> RUN.
  - RUN: stays in RUN unless the optional halt condition fires.
  - HALT: start -> RUN.
  - start while in RUN is ignored.
  - running=(state==RUN); halted=(state==HALT).
- Fetch fires when state==RUN && !redirect_valid && (!out_valid || out_ready). On fire:
  - out_ins<=imem_data, out_pc<=pc, out_valid<=1.
  - pc<=pc+1, modulo 2**PC_WIDTH, so 255 wraps to 0 with no flag.
- Throughput: one instruction per cycle while out_ready=1. Latency from the start pulse to first out_valid=1 is 2 cycles: state becomes RUN at edge 1, first fetch fires at edge 2.
- Accept without refill: if out_valid && out_ready and the fetch does not fire (not in RUN, or redirect), then out_valid<=0.
- Stall: while out_valid=1 && out_ready=0, out_valid, out_ins, out_pc and pc are held stable.
- Redirect:
  - redirect_valid=1 in any state: pc<=redirect_target and out_valid<=0, flushing even an unaccepted instruction.
  - No fetch fires in the redirect cycle.
  - FSM state is unchanged.
  - The first instruction from the target appears 1 cycle later in RUN.
- Simultaneous events:
  - redirect and out_ready=1 with out_valid=1: the held instruction is treated as consumed by decode; out_valid still drops.
  - redirect and start in IDLE: both take effect; pc=target and state=RUN.
- Start in HALT resumes at the current pc, which was not advanced past the halting instruction (see optional feature).

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - A fetch whose imem_data equals all-ones is still delivered to decode (out_valid=1, out_ins=all-ones).
  - In the same cycle the FSM goes RUN->HALT and pc is NOT incremented.
  - A later start re-fetches the same halt word unless a redirect occurs first.
  - A redirect in the halting cycle takes priority: no fetch, no halt.
- Undefined: all-ones is an ordinary instruction and HALT is never entered from RUN. halted stays 0 after reset.

Test Plan:
- Reset mid-stream: rst=1 while running with out_valid=1 -> next cycle out_valid=0, pc/imem_addr=0, running=0, halted=0.
- Streaming: memory holds word k = k; pulse start with out_ready=1 -> out_valid rises 2 cycles after start; out_pc/out_ins = 0,1,2,... one per cycle; after 255, out_pc=0 (wrap).
- Backpressure: out_ready=0 for 3 cycles while out_pc=5 -> out_ins/out_pc stay 5 and imem_addr stays 6. Raise out_ready -> 5 accepted, then 6 delivered with no skips or duplicates.
- Redirect: redirect_valid=1, target=0x40 while out_valid=1 and out_ready=0 -> next cycle out_valid=0; the cycle after, out_pc=0x40, out_ins=mem[0x40].
- Redirect plus start in IDLE with target=0x10 -> running=1 and pc=0x10; first out_pc=0x10 one cycle later.
- With FETCH_HALT_DETECT_EN, mem[3]=all-ones -> out_ins=all-ones at out_pc=3, halted=1, imem_addr stays 3. Without the macro, fetch continues to out_pc=4.
